led_data_reporter: RTL and testbench
====================================

LED_DATA_REPORTER -- requirements
Module: led_data_reporter

Interface
REQ-001 SHALL have parameter MEM_AW, default 8: number of low address bits that index each LED buffer.
REQ-002 SHALL have parameter RD_LAT, default 1, range 1..4: LED buffer read latency in clocks.
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  readback request strobe.
REQ-006 SHALL have port req_addr  in  32  requested address; bit31 = channel (0 = LED0, 1 = LED1).
REQ-007 SHALL have port req_ready  out  1  high when a request can be accepted.
REQ-008 SHALL have port LED0_RdAddr  out  MEM_AW  LED0 buffer read address.
REQ-009 SHALL have port LED0_RdData  in  32  LED0 buffer read data.
REQ-010 SHALL have port LED1_RdAddr  out  MEM_AW  LED1 buffer read address.
REQ-011 SHALL have port LED1_RdData  in  32  LED1 buffer read data.
REQ-012 SHALL have port UART_Tx  out  8  byte to transmit.
REQ-013 SHALL have port UART_TxStart  out  1  one-cycle transmit start pulse.
REQ-014 SHALL have port UART_TxBusy  in  1  transmitter busy.

Function
REQ-015 SHALL accept a request when req_valid and req_ready are both high in the same cycle, latching req_addr; req_valid while req_ready is low is ignored and not queued.
REQ-016 SHALL drive req_ready high only in IDLE.
REQ-017 SHALL implement states IDLE -> READ -> LOAD -> SEND -> GUARD -> WAIT -> (SEND, or IDLE after the last byte).
REQ-018 On acceptance, SHALL drive req_addr[MEM_AW-1:0] onto the read address of the selected channel; the other channel's read address SHALL hold its previous value.
REQ-019 SHALL remain in READ for exactly RD_LAT cycles, then capture the selected channel's RdData in LOAD.
REQ-020 SHALL build the frame: bytes 0..3 = latched req_addr little-endian, with bit31 echoed unchanged; bytes 4..7 = captured data little-endian.
REQ-021 In SEND, SHALL wait for UART_TxBusy == 0, then present the current byte on UART_Tx and pulse UART_TxStart high for exactly one cycle.
REQ-022 SHALL hold UART_Tx stable from the start pulse until the next SEND.
REQ-023 GUARD SHALL last exactly one cycle, with UART_TxBusy ignored; WAIT SHALL exit when UART_TxBusy == 0.
REQ-024 SHALL use a 4-bit byte index that increments after each start pulse; the frame ends when the index reaches the frame length.
REQ-025 Address bits [30:MEM_AW] SHALL be echoed in the frame but SHALL NOT affect the buffer read.
REQ-026 Minimum latency from request acceptance to first UART_TxStart SHALL be RD_LAT + 2 cycles when UART_TxBusy is low.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, byte index 0, and all outputs to the following values: req_ready = 1 (IDLE), UART_TxStart = 0, UART_Tx = 0x00, LED0_RdAddr = 0, LED1_RdAddr = 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no further start pulses; the first request after release SHALL produce a complete frame.

Configuration
REQ-029 When LED_REPORT_CHECKSUM_EN is defined, the frame SHALL be 9 bytes, with byte 8 = XOR of bytes 0..7.
REQ-030 When LED_REPORT_CHECKSUM_EN is undefined, the frame SHALL be 8 bytes and no checksum logic SHALL be present.

Verification
REQ-031 Bench SHALL cover: req_addr = 0x00000005, LED0[5] = 0x11223344, TxBusy idle -> UART_Tx sequence 05 00 00 00 44 33 22 11, 8 start pulses.
REQ-032 Bench SHALL cover: req_addr = 0x80000003, LED1[3] = 0xAABBCCDD -> sequence 03 00 00 80 DD CC BB AA; LED0_RdAddr unchanged.
REQ-033 Bench SHALL cover: TxBusy held high 20 cycles after each start -> exactly one start pulse per byte; none while busy.
REQ-034 Bench SHALL cover: req_valid pulsed during SEND -> ignored, exactly one frame sent.
REQ-035 Bench SHALL cover: reset asserted after byte 3 -> no further start pulses; the next request produces a full frame.
REQ-036 Bench SHALL cover, with LED_REPORT_CHECKSUM_EN defined: REQ-031 stimulus -> ninth byte 0x41.

Source files
------------

// File: rtl/led_data_reporter.sv
// led_data_reporter: reads one LED buffer word and sends {addr, data} bytes over UART.
// Defining LED_REPORT_CHECKSUM_EN appends an XOR checksum byte to each frame.
module led_data_reporter #(
    parameter int MEM_AW = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic [MEM_AW-1:0] LED0_RdAddr,
    input  logic [31:0]       LED0_RdData,
    output logic [MEM_AW-1:0] LED1_RdAddr,
    input  logic [31:0]       LED1_RdData,
    output logic [7:0]        UART_Tx,
    output logic              UART_TxStart,
    input  logic              UART_TxBusy
);
`ifdef LED_REPORT_CHECKSUM_EN
    localparam logic [3:0] FRAME_LEN = 4'd9;
`else
    localparam logic [3:0] FRAME_LEN = 4'd8;
`endif
    typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, GUARD, WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  lat_cnt;
    logic [3:0]  idx;
    logic [7:0]  tx_q;
    logic [7:0]  cur_byte;
    logic [63:0] frame;
    logic        accept;
    assign frame = {data_q, addr_q};
`ifdef LED_REPORT_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = frame[7:0] ^ frame[15:8] ^ frame[23:16] ^ frame[31:24]
                ^ frame[39:32] ^ frame[47:40] ^ frame[55:48] ^ frame[63:56];
    assign cur_byte = (idx == 4'd8) ? csum : frame[{idx[2:0], 3'b000} +: 8];
`else
    assign cur_byte = frame[{idx[2:0], 3'b000} +: 8];
`endif
    assign req_ready    = state == IDLE;
    assign accept       = req_valid && req_ready;
    assign UART_TxStart = state == SEND && !UART_TxBusy;
    // The byte register only loads on the pulse, so UART_Tx holds until the next one
    assign UART_Tx      = UART_TxStart ? cur_byte : tx_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? READ : IDLE;
            READ:    state_nx = (lat_cnt == 3'(RD_LAT)) ? LOAD : READ;
            LOAD:    state_nx = SEND;
            SEND:    state_nx = UART_TxBusy ? SEND : GUARD;
            GUARD:   state_nx = WAIT;
            WAIT:    state_nx = UART_TxBusy ? WAIT : (idx == FRAME_LEN) ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            lat_cnt     <= '0;
            idx         <= '0;
            tx_q        <= '0;
            LED0_RdAddr <= '0;
            LED1_RdAddr <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                lat_cnt <= 3'd1;
                idx     <= '0;
                if (req_addr[31])
                    LED1_RdAddr <= req_addr[MEM_AW-1:0];
                else
                    LED0_RdAddr <= req_addr[MEM_AW-1:0];
            end
            if (state == READ)
                lat_cnt <= lat_cnt + 3'd1;
            if (state == LOAD)
                data_q <= addr_q[31] ? LED1_RdData : LED0_RdData;
            if (UART_TxStart) begin
                tx_q <= cur_byte;
                idx  <= idx + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_led_data_reporter.sv
// tb_led_data_reporter: vector table of readback requests against a byte scoreboard,
// plus hand sequences for request-during-frame and mid-frame reset.
module tb_led_data_reporter;
    localparam int AW  = 8;
    localparam int RDL = 2;
`ifdef LED_REPORT_CHECKSUM_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          blen;
        logic [31:0] poke;
        int          lat;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          req_ready;
    logic [AW-1:0] led0_addr;
    logic [AW-1:0] led1_addr;
    logic [31:0]   led0_data;
    logic [31:0]   led1_data;
    logic [7:0]    tx;
    logic          tx_start;
    logic          tx_busy;
    int            checks = 0;
    int            fails = 0;
    int            pulses = 0;
    int            busy_len = 0;
    int            busy_cnt = 0;
    logic [7:0]    last_tx = 8'h00;
    logic [7:0]    exp_q[$];
    logic [31:0]   mem0[256];
    logic [31:0]   mem1[256];
    logic [31:0]   p0[RDL];
    logic [31:0]   p1[RDL];

    always #5 clock = ~clock;

    led_data_reporter #(.MEM_AW(AW), .RD_LAT(RDL)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .LED0_RdAddr(led0_addr), .LED0_RdData(led0_data),
        .LED1_RdAddr(led1_addr), .LED1_RdData(led1_data), .UART_Tx(tx),
        .UART_TxStart(tx_start), .UART_TxBusy(tx_busy)
    );

    // Buffers with RDL clocks of read latency
    assign led0_data = p0[RDL-1];
    assign led1_data = p1[RDL-1];
    always @(posedge clock) begin
        p0[0] <= mem0[led0_addr];
        p1[0] <= mem1[led1_addr];
        for (int i = 1; i < RDL; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end

    // Transmitter stays busy for busy_len cycles after each start
    assign tx_busy = busy_cnt != 0;
    always @(posedge clock) begin
        if (reset)
            busy_cnt <= 0;
        else if (tx_start)
            busy_cnt <= busy_len;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset)
            last_tx = 8'h00;
        else if (tx_start) begin
            pulses++;
            check("busy_at_start", 32'(tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_start: got byte %h, expected no start pulse", tx);
            end else
                check("tx_byte", 32'(tx), 32'(exp_q.pop_front()));
            last_tx = tx;
        end else
            check("tx_hold", 32'(tx), 32'(last_tx));
    end

    task automatic push_frame(input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] fr[9];
        fr[8] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            fr[i]   = addr[8*i +: 8];
            fr[i+4] = data[8*i +: 8];
        end
        for (int i = 0; i < 8; i++)
            fr[8] ^= fr[i];
        for (int i = 0; i < FL; i++)
            exp_q.push_back(fr[i]);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        check({name, "_start"}, 32'(tx_start), 32'd0);
        check({name, "_tx"}, 32'(tx), 32'd0);
        check({name, "_led0_addr"}, 32'(led0_addr), 32'd0);
        check({name, "_led1_addr"}, 32'(led1_addr), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 2000) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("frame_timeout", 32'(n >= 2000), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input vec_t v, output int lat);
        int n;
        push_frame(v.addr, v.data);
        busy_len = v.blen;
        pulses = 0;
        check("ready_idle", 32'(req_ready), 32'd1);
        req_addr = v.addr;
        req_valid = 1'b1;
        @(negedge clock);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!tx_start && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        lat = n;
        if (v.poke != 0) begin
            check("ready_in_send", 32'(req_ready), 32'd0);
            req_addr = v.poke;
            req_valid = 1'b1;
            @(negedge clock);
            #1;
            req_valid = 1'b0;
        end
        wait_done();
        repeat (RDL + 12) @(negedge clock);
        #1;
        check("pulse_count", pulses, FL);
    endtask

    initial begin
        vec_t          v[7];
        int            lat;
        logic [AW-1:0] other;
        v[0] = '{32'h00000005, 32'h11223344, 0,  32'h0, RDL + 2};
        v[1] = '{32'h80000003, 32'hAABBCCDD, 0,  32'h0, RDL + 2};
        v[2] = '{32'h00000007, 32'hCAFEF00D, 20, 32'h0, RDL + 2};
        v[3] = '{32'h7FFFFF05, 32'h11223344, 0,  32'h0, RDL + 2};
        v[4] = '{32'hFFFFFFFF, 32'h01020304, 5,  32'h0, RDL + 2};
        v[5] = '{32'h00000100, 32'h5A5AA5A5, 1,  32'h0, RDL + 2};
        v[6] = '{32'h80000003, 32'hAABBCCDD, 0,  32'h00000009, RDL + 2};
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h10000000 + 32'(i);
            mem1[i] = 32'h20000000 + 32'(i);
        end
        mem0[5]   = 32'h11223344;
        mem1[3]   = 32'hAABBCCDD;
        mem0[7]   = 32'hCAFEF00D;
        mem1[255] = 32'h01020304;
        mem0[0]   = 32'h5A5AA5A5;
        repeat (3) @(negedge clock);
        check_reset("reset");
        reset = 1'b0;
        @(negedge clock);
        #1;
        for (int i = 0; i < 7; i++) begin
            other = v[i].addr[31] ? led0_addr : led1_addr;
            run_frame(v[i], lat);
            check("latency", lat, v[i].lat);
            check("other_addr_held", 32'(v[i].addr[31] ? led0_addr : led1_addr), 32'(other));
        end
        begin
            int n = 0;
            push_frame(32'h00000005, 32'h11223344);
            busy_len = 3;
            pulses = 0;
            req_addr = 32'h00000005;
            req_valid = 1'b1;
            @(negedge clock);
            #1;
            req_valid = 1'b0;
            while (pulses < 4 && n < 500) begin
                @(negedge clock);
                #1;
                n++;
            end
            check("reach_byte3", pulses, 4);
            @(negedge clock);
            #1;
            reset = 1'b1;
            exp_q.delete();
            #1;
            check_reset("midframe_reset");
            @(negedge clock);
            #1;
            reset = 1'b0;
            repeat (40) @(negedge clock);
            #1;
            check("no_pulse_after_reset", pulses, 4);
        end
        run_frame(v[0], lat);
        check("latency_after_reset", lat, v[0].lat);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
